scratchpad_req_queue: RTL and testbench
=======================================

Name: scratchpad_req_queue

Overview:
- Parametrised request queue between the execute stage's matrix load/store FU (MLS) and GEMM FU, and the scratchpad.
- Arbitrates the two valid/ready sources round-robin.
- Encodes each granted request into a fixed packet and buffers it in a DEPTH-entry first-word-fall-through FIFO.
- Reports occupancy and almost-full so issue logic can throttle.

Parameters:
- ADDR_W, 32, matrix address width; must be >= 16.
- MAT_W, 4, matrix register index width.
- STRIDE_W, 5, stride field width.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH.
- Derived: PKT_W = 2+MAT_W+ADDR_W+STRIDE_W (43 at defaults); CNT_W = clog2(DEPTH)+1.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of queue and arbiter state.
- mls_valid  in  1  MLS request valid.
- mls_ready  out  1  MLS request accepted this cycle.
- mls_ls  in  2  01 load, 10 store; 00 and 11 are illegal.
- mls_rd  in  MAT_W  matrix register.
- mls_addr  in  ADDR_W  matrix base address.
- mls_stride  in  STRIDE_W  row stride.
- gemm_valid  in  1  GEMM request valid.
- gemm_ready  out  1  GEMM request accepted.
- gemm_new_weight  in  1  reload weights.
- gemm_sel  in  16  GEMM buffer select.
- sp_valid  out  1  head entry valid.
- sp_data  out  PKT_W  head packet.
- sp_pop  in  1  consume head; ignored when sp_valid=0.
- count  out  CNT_W  occupancy.
- almost_full  out  1  count >= AFULL_TH.
- err_illegal  out  1  one-cycle pulse when an illegal mls_ls is dropped.

Behaviour:
- Clock and reset: one clock CLK; reset nRST is asynchronous, active-low.
- Reset values:
  - Pointers = 0, count = 0, sp_valid = 0, sp_data = 0.
  - err_illegal = 0, almost_full = 0.
  - Round-robin pointer favours MLS.
- Packet format (MSB to LSB): {op[1:0], rd[MAT_W-1:0], addr[ADDR_W-1:0], stride[STRIDE_W-1:0]}.
  - MLS request: op = mls_ls, rd = mls_rd, addr = mls_addr, stride = mls_stride.
  - GEMM request: op = 2'b11, rd = {gemm_new_weight, (MAT_W-1)'b0}, addr = zero-extended gemm_sel, stride = 0.
- Grant (combinational, from registered state only; no path from sp_pop):
  - space = (count < DEPTH).
  - If one source is valid and space=1, that source is granted.
  - If both are valid, the source favoured by the RR pointer is granted.
  - The RR pointer flips to favour the other source after any grant.
  - mls_ready = MLS granted; gemm_ready = GEMM granted. At most one ready per cycle.
  - No grant while full, even if sp_pop=1 that cycle.
- Illegal MLS request (mls_ls = 00 or 11):
  - Is granted and consumes an arbitration turn like a legal request.
  - Is not written to the FIFO.
  - Pulses err_illegal in the next cycle.
- FIFO:
  - Write at the posedge of the grant cycle.
  - Entry is visible at the head (sp_valid=1) the cycle after the write: push-to-sp_valid latency is 1 cycle.
  - Pop advances the head at the edge where sp_pop & sp_valid.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - sp_data is the head entry; it holds its value when sp_valid=0.
  - count and almost_full are registered and consistent with sp_valid.
- flush:
  - At the next edge: count = 0, pointers = 0, RR pointer favours MLS.
  - Overrides a same-cycle push and pop.
  - Forces mls_ready = gemm_ready = 0 during the flush cycle.
- nRST mid-operation drops all entries immediately; the queue restarts empty.

Decomposition:
- Shared package: the opcode constants OP_LOAD = 2'b01, OP_STORE = 2'b10, OP_GEMM = 2'b11.
- Shared package: the PKT_W field offsets and a packet struct for the default widths, reused by the scratchpad.
- Sub-module: sync_fifo_fwft (generic width/depth FIFO with count). The arbiter and encoder stay in the top module.

Test Plan:
- Reset then idle: sp_valid=0, count=0, both readies 0.
- Single MLS load: mls_ls=01, rd=3, addr=32'h1000, stride=4. Expect mls_ready=1 that cycle; sp_valid=1 one cycle later; sp_data = {2'b01, 4'd3, 32'h1000, 5'd4}; pop gives count=0.
- Both sources valid continuously, sp_pop=1 every cycle:
  - Grants alternate MLS, GEMM, MLS, ...
  - GEMM packet with sel=16'h00A5 and new_weight=1 equals {2'b11, 4'b1000, 32'h000000A5, 5'd0}.
- Fill with no pops, DEPTH=8: after 8 grants, count=8, both readies 0, almost_full=1 since count reached 6. Then one pop, and one new grant occurs the next cycle.
- Wrap-around: push and pop 20 packets with random backpressure. Order is preserved and count never exceeds 8.
- Illegal and flush:
  - mls_ls=11 gives mls_ready=1, err_illegal pulses once, count unchanged.
  - Flush asserted with 5 entries and a simultaneous push gives count=0 and sp_valid=0 next cycle.

Source files
------------

// File: rtl/scratchpad_req_queue_pkg.sv
// -----------------------------------------------------------------------------
// scratchpad_req_queue_pkg
// Shared definitions for the scratchpad request queue and its consumers:
//   - opcode constants carried in the top two bits of every packet
//   - field offsets and a packed struct for the default packet layout
//     {op[1:0], rd[3:0], addr[31:0], stride[4:0]} (43 bits)
//   - small helpers for packet width and MLS opcode legality
// -----------------------------------------------------------------------------
package scratchpad_req_queue_pkg;

   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_GEMM  = 2'b11;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_MAT_W    = 4;
   localparam int DEF_STRIDE_W = 5;
   localparam int DEF_PKT_W    = 2 + DEF_MAT_W + DEF_ADDR_W + DEF_STRIDE_W;

   // Bit offsets (LSB of each field) within the default-width packet.
   localparam int PKT_STRIDE_LSB = 0;
   localparam int PKT_ADDR_LSB   = PKT_STRIDE_LSB + DEF_STRIDE_W;
   localparam int PKT_RD_LSB     = PKT_ADDR_LSB + DEF_ADDR_W;
   localparam int PKT_OP_LSB     = PKT_RD_LSB + DEF_MAT_W;

   typedef struct packed {
      logic [1:0]              op;
      logic [DEF_MAT_W-1:0]    rd;
      logic [DEF_ADDR_W-1:0]   addr;
      logic [DEF_STRIDE_W-1:0] stride;
   } sp_pkt_t;

   function automatic int calc_pkt_w(input int addr_w, input int mat_w, input int stride_w);
      return 2 + mat_w + addr_w + stride_w;
   endfunction

   function automatic logic is_legal_ls(input logic [1:0] ls);
      return (ls == OP_LOAD) || (ls == OP_STORE);
   endfunction

endpackage

// File: rtl/scratchpad_req_queue_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
// Generic first-word-fall-through FIFO with occupancy count and a registered
// almost-full flag.
//
// Ports:
//   CLK          in   clock, rising edge
//   nRST         in   asynchronous active-low reset
//   flush        in   synchronous clear (overrides push and pop)
//   push         in   write wdata (ignored when full)
//   wdata        in   WIDTH write data
//   pop          in   consume head (ignored when empty)
//   rvalid       out  head entry valid
//   rdata        out  WIDTH head entry; holds its value while rvalid=0
//   count        out  CNT_W occupancy
//   almost_full  out  count >= AFULL_TH
//
// rdata is a register loaded with the entry that will be at the head after
// the edge, so it holds steady when the FIFO drains instead of showing
// whatever stale slot the read pointer has moved onto.
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
   parameter int WIDTH    = 43,
   parameter int DEPTH    = 8,
   parameter int AFULL_TH = 6,
   parameter int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             rvalid,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             almost_full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] head_idx_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             full;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign push_ok = push && !full;
   assign pop_ok  = pop && rvalid;

   always_comb begin
      cnt_nxt = count;
      if (push_ok && !pop_ok) begin
         cnt_nxt = count + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         cnt_nxt = count - CNT_W'(1);
      end
   end

   // The write slot only coincides with the next head slot when the pushed
   // word is the only entry after this edge; bypass it straight to rdata.
   always_comb begin
      head_idx_nxt = pop_ok ? (rd_ptr + PTR_W'(1)) : rd_ptr;
      head_nxt     = mem[head_idx_nxt];
      if (push_ok && (wr_ptr == head_idx_nxt)) begin
         head_nxt = wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rvalid      <= 1'b0;
         rdata       <= '0;
         almost_full <= 1'b0;
      end else if (flush) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rvalid      <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count       <= cnt_nxt;
         rvalid      <= (cnt_nxt != '0);
         almost_full <= (cnt_nxt >= CNT_W'(AFULL_TH));
         if (cnt_nxt != '0) begin
            rdata <= head_nxt;
         end
      end
   end

endmodule

// File: rtl/scratchpad_req_queue.sv
// -----------------------------------------------------------------------------
// scratchpad_req_queue
// Request queue between the MLS and GEMM functional units and the scratchpad.
// Round-robin arbitrates the two valid/ready sources, encodes each grant into
// a fixed packet and buffers it in a DEPTH-entry FWFT FIFO.
//
// Ports:
//   CLK, nRST                      clock, async active-low reset
//   flush                          synchronous clear of queue and arbiter
//   mls_valid/mls_ready            MLS handshake
//   mls_ls, mls_rd, mls_addr,      MLS request fields (ls: 01 load, 10 store;
//   mls_stride                       00/11 are dropped with err_illegal)
//   gemm_valid/gemm_ready          GEMM handshake
//   gemm_new_weight, gemm_sel      GEMM request fields
//   sp_valid, sp_data, sp_pop      scratchpad side of the FIFO
//   count, almost_full             occupancy for issue throttling
//   err_illegal                    one-cycle pulse after an illegal MLS drop
//
// Packet: {op[1:0], rd[MAT_W-1:0], addr[ADDR_W-1:0], stride[STRIDE_W-1:0]}.
// ADDR_W must be at least 16 so gemm_sel fits in the address field; DEPTH
// must be a power of two so the FIFO pointers wrap naturally.
//
// Grants depend only on registered state (count, rr pointer) plus the request
// valids, never on sp_pop, so a full queue grants nothing even while popping.
// -----------------------------------------------------------------------------
module scratchpad_req_queue
   import scratchpad_req_queue_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int MAT_W    = 4,
   parameter int STRIDE_W = 5,
   parameter int DEPTH    = 8,
   parameter int AFULL_TH = 6
) (
   input  logic                                   CLK,
   input  logic                                   nRST,
   input  logic                                   flush,
   input  logic                                   mls_valid,
   output logic                                   mls_ready,
   input  logic [1:0]                             mls_ls,
   input  logic [MAT_W-1:0]                       mls_rd,
   input  logic [ADDR_W-1:0]                      mls_addr,
   input  logic [STRIDE_W-1:0]                    mls_stride,
   input  logic                                   gemm_valid,
   output logic                                   gemm_ready,
   input  logic                                   gemm_new_weight,
   input  logic [15:0]                            gemm_sel,
   output logic                                   sp_valid,
   output logic [2+MAT_W+ADDR_W+STRIDE_W-1:0]     sp_data,
   input  logic                                   sp_pop,
   output logic [$clog2(DEPTH):0]                 count,
   output logic                                   almost_full,
   output logic                                   err_illegal
);

   localparam int PKT_W = calc_pkt_w(ADDR_W, MAT_W, STRIDE_W);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             rr_mls;
   logic             space;
   logic             mls_grant;
   logic             gemm_grant;
   logic             mls_legal;
   logic             fifo_push;
   logic [PKT_W-1:0] mls_pkt;
   logic [PKT_W-1:0] gemm_pkt;
   logic [PKT_W-1:0] fifo_wdata;

   assign space     = (count < CNT_W'(DEPTH));
   assign mls_legal = is_legal_ls(mls_ls);

   always_comb begin
      mls_grant  = 1'b0;
      gemm_grant = 1'b0;
      if (!flush && space) begin
         if (mls_valid && (!gemm_valid || rr_mls)) begin
            mls_grant = 1'b1;
         end else if (gemm_valid) begin
            gemm_grant = 1'b1;
         end
      end
   end

   assign mls_ready  = mls_grant;
   assign gemm_ready = gemm_grant;

   assign mls_pkt  = {mls_ls, mls_rd, mls_addr, mls_stride};
   assign gemm_pkt = {OP_GEMM, gemm_new_weight, {(MAT_W-1){1'b0}},
                      ADDR_W'(gemm_sel), {STRIDE_W{1'b0}}};

   // Illegal MLS opcodes still win arbitration (and flip the pointer) but
   // never reach the FIFO.
   assign fifo_push  = (mls_grant && mls_legal) || gemm_grant;
   assign fifo_wdata = mls_grant ? mls_pkt : gemm_pkt;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_mls      <= 1'b1;
         err_illegal <= 1'b0;
      end else if (flush) begin
         rr_mls      <= 1'b1;
         err_illegal <= 1'b0;
      end else begin
         if (mls_grant) begin
            rr_mls <= 1'b0;
         end else if (gemm_grant) begin
            rr_mls <= 1'b1;
         end
         err_illegal <= mls_grant && !mls_legal;
      end
   end

   sync_fifo_fwft #(
      .WIDTH    (PKT_W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH),
      .CNT_W    (CNT_W)
   ) u_fifo (
      .CLK         (CLK),
      .nRST        (nRST),
      .flush       (flush),
      .push        (fifo_push),
      .wdata       (fifo_wdata),
      .pop         (sp_pop),
      .rvalid      (sp_valid),
      .rdata       (sp_data),
      .count       (count),
      .almost_full (almost_full)
   );

endmodule

// File: tb/tb_scratchpad_req_queue.sv
module tb_scratchpad_req_queue;
   import scratchpad_req_queue_pkg::*;

   localparam int ADDR_W = 32, MAT_W = 4, STRIDE_W = 5, DEPTH = 8, AFULL_TH = 6;
   localparam int PKT_W = 43, CNT_W = 4;

   logic              CLK = 1'b0;
   logic              nRST;
   logic              flush;
   logic              mls_valid, mls_ready;
   logic [1:0]        mls_ls;
   logic [MAT_W-1:0]  mls_rd;
   logic [ADDR_W-1:0] mls_addr;
   logic [STRIDE_W-1:0] mls_stride;
   logic              gemm_valid, gemm_ready, gemm_new_weight;
   logic [15:0]       gemm_sel;
   logic              sp_valid, sp_pop, almost_full, err_illegal;
   logic [PKT_W-1:0]  sp_data;
   logic [CNT_W-1:0]  count;

   scratchpad_req_queue #(
      .ADDR_W(ADDR_W), .MAT_W(MAT_W), .STRIDE_W(STRIDE_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
   ) dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .mls_valid(mls_valid), .mls_ready(mls_ready), .mls_ls(mls_ls), .mls_rd(mls_rd),
      .mls_addr(mls_addr), .mls_stride(mls_stride),
      .gemm_valid(gemm_valid), .gemm_ready(gemm_ready), .gemm_new_weight(gemm_new_weight),
      .gemm_sel(gemm_sel),
      .sp_valid(sp_valid), .sp_data(sp_data), .sp_pop(sp_pop),
      .count(count), .almost_full(almost_full), .err_illegal(err_illegal)
   );

   always #5 CLK = ~CLK;

   // Reference model: a queue of packets, whose turn it is, and a pending error.
   logic [PKT_W-1:0] exp_q[$];
   bit               favour_mls;
   bit               exp_err;
   int               total = 0;
   int               bad   = 0;

   function automatic logic [PKT_W-1:0] mk_mls(input logic [1:0] ls, input logic [3:0] rd,
                                               input logic [31:0] addr, input logic [4:0] st);
      return {ls, rd, addr, st};
   endfunction

   function automatic logic [PKT_W-1:0] mk_gemm(input logic nw, input logic [15:0] sel);
      return {2'b11, nw, 3'b000, 16'h0000, sel, 5'd0};
   endfunction

   function automatic void exp_grant(output bit gm, output bit gg);
      bit room;
      room = exp_q.size() < DEPTH;
      gm = !flush && room && mls_valid && (!gemm_valid || favour_mls);
      gg = !flush && room && gemm_valid && !gm;
   endfunction

   task automatic idle_inputs();
      flush = 0; mls_valid = 0; gemm_valid = 0; sp_pop = 0;
      mls_ls = 2'b01; mls_rd = '0; mls_addr = '0; mls_stride = '0;
      gemm_new_weight = 0; gemm_sel = '0;
   endtask

   task automatic rand_mls(input bit allow_illegal);
      mls_ls     = allow_illegal ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      mls_rd     = 4'($urandom_range(0, 15));
      mls_addr   = $urandom();
      mls_stride = 5'($urandom_range(0, 31));
   endtask

   // Advance one clock edge and update the model; returns #1 after the edge.
   task automatic edge_update();
      bit gm, gg;
      logic [PKT_W-1:0] tmp;
      exp_grant(gm, gg);
      @(posedge CLK);
      if (flush) begin
         exp_q.delete();
         favour_mls = 1;
         exp_err = 0;
      end else begin
         if (sp_pop && exp_q.size() > 0) tmp = exp_q.pop_front();
         if (gm) begin
            if (mls_ls == 2'b01 || mls_ls == 2'b10)
               exp_q.push_back(mk_mls(mls_ls, mls_rd, mls_addr, mls_stride));
            favour_mls = 0;
         end else if (gg) begin
            exp_q.push_back(mk_gemm(gemm_new_weight, gemm_sel));
            favour_mls = 1;
         end
         exp_err = gm && !(mls_ls == 2'b01 || mls_ls == 2'b10);
      end
      #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      nRST = 0;
      exp_q.delete(); favour_mls = 1; exp_err = 0;
      repeat (2) @(posedge CLK);
      #1;
      total++;
      if (sp_valid !== 1'b0 || count !== '0 || sp_data !== '0 || almost_full !== 1'b0 ||
          err_illegal !== 1'b0 || mls_ready !== 1'b0 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset: sp_valid=%b count=%0d sp_data=%h af=%b err=%b rdy=%b%b required all zero",
                  sp_valid, count, sp_data, almost_full, err_illegal, mls_ready, gemm_ready);
      end
      nRST = 1;
      edge_update();
      total++;
      if (sp_valid !== 1'b0 || count !== '0) begin
         bad++;
         $display("FAIL idle: sp_valid=%b count=%0d required 0 0", sp_valid, count);
      end
   endtask

   task automatic test_single_load();
      mls_valid = 1; mls_ls = 2'b01; mls_rd = 4'd3; mls_addr = 32'h1000; mls_stride = 5'd4;
      #1;
      total++;
      if (mls_ready !== 1'b1 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL load_ready: mls_ready=%b gemm_ready=%b required 1 0", mls_ready, gemm_ready);
      end
      edge_update();
      mls_valid = 0;
      total++;
      if (sp_valid !== 1'b1 || count !== 4'd1 || sp_data !== {2'b01, 4'd3, 32'h1000, 5'd4}) begin
         bad++;
         $display("FAIL load_head: sp_valid=%b count=%0d sp_data=%h required 1 1 %h",
                  sp_valid, count, sp_data, {2'b01, 4'd3, 32'h1000, 5'd4});
      end
      sp_pop = 1;
      edge_update();
      sp_pop = 0;
      total++;
      if (count !== '0 || sp_valid !== 1'b0) begin
         bad++;
         $display("FAIL load_pop: count=%0d sp_valid=%b required 0 0", count, sp_valid);
      end
   endtask

   task automatic test_alternate();
      bit gm, gg, prev_gm;
      mls_valid = 1; gemm_valid = 1; sp_pop = 1;
      gemm_new_weight = 1; gemm_sel = 16'h00A5;
      prev_gm = !favour_mls;
      for (int i = 0; i < 10; i++) begin
         rand_mls(0);
         #1;
         exp_grant(gm, gg);
         total++;
         if (mls_ready !== gm || gemm_ready !== gg || gm == prev_gm) begin
            bad++;
            $display("FAIL alt_grant[%0d]: rdy=%b%b required %b%b (prev mls=%b)",
                     i, mls_ready, gemm_ready, gm, gg, prev_gm);
         end
         prev_gm = gm;
         edge_update();
         if (gg) begin
            total++;
            if (sp_data !== {2'b11, 4'b1000, 32'h000000A5, 5'd0}) begin
               bad++;
               $display("FAIL alt_gemm_pkt: sp_data=%h required %h",
                        sp_data, {2'b11, 4'b1000, 32'h000000A5, 5'd0});
            end
         end else begin
            total++;
            if (sp_data !== exp_q[0] || count !== 4'd1) begin
               bad++;
               $display("FAIL alt_mls_pkt: sp_data=%h count=%0d required %h 1", sp_data, count, exp_q[0]);
            end
         end
      end
      idle_inputs();
      sp_pop = 1;
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) edge_update();
      sp_pop = 0;
   endtask

   task automatic test_fill();
      bit gm, gg;
      idle_inputs();
      mls_valid = 1; gemm_valid = 1;
      for (int i = 0; i < 9; i++) begin
         rand_mls(0);
         gemm_sel = 16'($urandom()); gemm_new_weight = 1'($urandom_range(0, 1));
         #1;
         exp_grant(gm, gg);
         total++;
         if (mls_ready !== gm || gemm_ready !== gg) begin
            bad++;
            $display("FAIL fill_grant[%0d]: rdy=%b%b required %b%b", i, mls_ready, gemm_ready, gm, gg);
         end
         edge_update();
         total++;
         if (count !== exp_q.size() || almost_full !== (exp_q.size() >= AFULL_TH)) begin
            bad++;
            $display("FAIL fill_count[%0d]: count=%0d af=%b required %0d %b",
                     i, count, almost_full, exp_q.size(), exp_q.size() >= AFULL_TH);
         end
      end
      total++;
      if (count !== 4'd8 || almost_full !== 1'b1 || mls_ready !== 1'b0 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL full: count=%0d af=%b rdy=%b%b required 8 1 00",
                  count, almost_full, mls_ready, gemm_ready);
      end
      sp_pop = 1;
      #1;
      total++;
      if (mls_ready !== 1'b0 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_pop_grant: rdy=%b%b required 00", mls_ready, gemm_ready);
      end
      edge_update();
      sp_pop = 0;
      total++;
      if (count !== 4'd7 || (mls_ready | gemm_ready) !== 1'b1) begin
         bad++;
         $display("FAIL after_pop: count=%0d any_ready=%b required 7 1", count, mls_ready | gemm_ready);
      end
      edge_update();
      total++;
      if (count !== 4'd8) begin
         bad++;
         $display("FAIL refill: count=%0d required 8", count);
      end
      idle_inputs();
      sp_pop = 1;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
         total++;
         if (sp_data !== exp_q[0] || sp_valid !== 1'b1) begin
            bad++;
            $display("FAIL fill_drain[%0d]: sp_data=%h sp_valid=%b required %h 1", i, sp_data, sp_valid, exp_q[0]);
         end
         edge_update();
      end
      sp_pop = 0;
      total++;
      if (count !== '0 || sp_valid !== 1'b0) begin
         bad++;
         $display("FAIL fill_empty: count=%0d sp_valid=%b required 0 0", count, sp_valid);
      end
   endtask

   task automatic test_wrap();
      bit gm, gg;
      int pushed = 0;
      int cyc = 0;
      while (pushed < 20 && cyc < 400) begin
         mls_valid = 1'($urandom_range(0, 1));
         gemm_valid = 1'($urandom_range(0, 1));
         rand_mls(1);
         gemm_sel = 16'($urandom()); gemm_new_weight = 1'($urandom_range(0, 1));
         sp_pop = ($urandom_range(0, 2) != 0);
         #1;
         exp_grant(gm, gg);
         total++;
         if (mls_ready !== gm || gemm_ready !== gg) begin
            bad++;
            $display("FAIL wrap_grant[%0d]: rdy=%b%b required %b%b", cyc, mls_ready, gemm_ready, gm, gg);
         end
         if ((gm && (mls_ls == 2'b01 || mls_ls == 2'b10)) || gg) pushed++;
         edge_update();
         total++;
         if (count !== exp_q.size() || count > 4'd8 || sp_valid !== (exp_q.size() > 0) ||
             (exp_q.size() > 0 && sp_data !== exp_q[0]) || err_illegal !== exp_err) begin
            bad++;
            $display("FAIL wrap_state[%0d]: count=%0d sp_valid=%b sp_data=%h err=%b required %0d %b %h %b",
                     cyc, count, sp_valid, sp_data, err_illegal, exp_q.size(), exp_q.size() > 0,
                     (exp_q.size() > 0) ? exp_q[0] : sp_data, exp_err);
         end
         cyc++;
      end
      total++;
      if (pushed < 20) begin
         bad++;
         $display("FAIL wrap_budget: pushed=%0d required 20", pushed);
      end
      idle_inputs();
      sp_pop = 1;
      for (int i = 0; i < 12 && exp_q.size() > 0; i++) begin
         total++;
         if (sp_data !== exp_q[0]) begin
            bad++;
            $display("FAIL wrap_drain[%0d]: sp_data=%h required %h", i, sp_data, exp_q[0]);
         end
         edge_update();
      end
      sp_pop = 0;
   endtask

   task automatic test_illegal();
      idle_inputs();
      mls_valid = 1; mls_ls = 2'b11; mls_addr = 32'hDEAD0000;
      #1;
      total++;
      if (mls_ready !== 1'b1) begin
         bad++;
         $display("FAIL illegal_ready: mls_ready=%b required 1", mls_ready);
      end
      edge_update();
      mls_valid = 0;
      total++;
      if (err_illegal !== 1'b1 || count !== '0 || sp_valid !== 1'b0) begin
         bad++;
         $display("FAIL illegal_pulse: err=%b count=%0d sp_valid=%b required 1 0 0", err_illegal, count, sp_valid);
      end
      edge_update();
      total++;
      if (err_illegal !== 1'b0) begin
         bad++;
         $display("FAIL illegal_once: err=%b required 0", err_illegal);
      end
   endtask

   task automatic test_flush();
      idle_inputs();
      mls_valid = 1;
      for (int i = 0; i < 5; i++) begin
         rand_mls(0);
         edge_update();
      end
      total++;
      if (count !== 4'd5) begin
         bad++;
         $display("FAIL flush_prefill: count=%0d required 5", count);
      end
      flush = 1; sp_pop = 1; gemm_valid = 1;
      #1;
      total++;
      if (mls_ready !== 1'b0 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_ready: rdy=%b%b required 00", mls_ready, gemm_ready);
      end
      edge_update();
      flush = 0; sp_pop = 0;
      total++;
      if (count !== '0 || sp_valid !== 1'b0 || almost_full !== 1'b0) begin
         bad++;
         $display("FAIL flush_clear: count=%0d sp_valid=%b af=%b required 0 0 0", count, sp_valid, almost_full);
      end
      #1;
      total++;
      if (mls_ready !== 1'b1 || gemm_ready !== 1'b0) begin
         bad++;
         $display("FAIL flush_rr: rdy=%b%b required 10", mls_ready, gemm_ready);
      end
      edge_update();
      edge_update();
      idle_inputs();
      #2;
      nRST = 0;
      #1;
      total++;
      if (count !== '0 || sp_valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: count=%0d sp_valid=%b required 0 0", count, sp_valid);
      end
      exp_q.delete(); favour_mls = 1; exp_err = 0;
      @(posedge CLK);
      #1;
      nRST = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single_load();
      test_alternate();
      test_fill();
      test_wrap();
      test_illegal();
      test_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
